data_frag_rd_ctrl: RTL
======================

# data_frag_rd_ctrl

Read-side sequencer and occupancy manager for the TX data-fragmentation TLP buffer (257 locations × 4 DW).
- Tracks the circular write and read pointers and the location count.
- Accepts one TLP descriptor at a time and reads the stored TLP out as 8-DW beats, two buffer locations per beat.
- Drives beat framing (SOP/EOP/valid DW length) to the ECRC generator and the downstream TX path.
- Sits between the buffer write port (fed by the AXI-side TLP assembler) and the ECRC/fragmentation datapath.

## Interface
- BUF_DEPTH, 257, buffer locations (each 4 DW)
- ADDR_WIDTH, 9, buffer address width
- COUNT_WIDTH, 9, occupancy counter width
- NO_LOC_WR_WIDTH, 4, locations written per write (1..9)
- TLP_DW_WIDTH, 11, TLP length field in DW (1..1028)
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  buffer write this cycle
- wr_loc_num  in  4  locations written (1..9)
- wr_ptr  out  9  next write address
- buf_count  out  9  occupied locations
- buf_full  out  1  buf_count > BUF_DEPTH−9
- wr_ovf  out  1  one-cycle pulse: write dropped
- tlp_start  in  1  descriptor valid
- tlp_total_dw  in  11  stored TLP length in DW, header+data
- tlp_ready  out  1  descriptor accepted when high with tlp_start
- beat_ready  in  1  downstream takes a beat one cycle after this is sampled
- rd_en  out  1  buffer read strobe (combinational)
- rd_addr0, rd_addr1  out  9 each  read addresses
- rd_loc_num  out  2  locations read (1 or 2)
- beat_valid, beat_sop, beat_eop  out  1 each  framing, aligned with buffer read data
- beat_dw_len  out  4  valid DW in beat (1..8)
- ecrc_insert  out  1  ECRC slot beat

## Operation
- **Occupancy**
  - buf_count(next) = buf_count + (wr_en ? wr_loc_num : 0) − (rd_en ? rd_loc_num : 0). Simultaneous write and read are both applied.
  - A write with buf_count + wr_loc_num > 257 is dropped. On a drop: wr_ptr and buf_count are unchanged and wr_ovf pulses.
- **Pointers**
  - Pointers advance modulo 257: 256 + 1 → 0.
  - rd_addr1 = rd_addr0 + 1 modulo 257.
- **Descriptor acceptance**
  - Needed locations L = ceil(tlp_total_dw/4); beats B = ceil(tlp_total_dw/8).
  - tlp_ready = (state == IDLE) & (buf_count ≥ L).
  - On acceptance the block latches the length and enters SEND.
- **FSM states:** IDLE, SEND, ECRC.
  - **IDLE:** waits for acceptance, then → SEND.
  - **SEND:** one beat issued per cycle while beat_ready = 1 (rd_en = 1); beat_ready = 0 holds issue.
    - Every beat reads 2 locations, except the last beat, which reads 1 location when L is odd.
    - beat_dw_len is 8 on every beat except the last, where it is tlp_total_dw − 8(B−1).
    - beat_sop is set on the first beat; beat_eop on the last.
    - After issuing the last beat: → ECRC if the macro is defined, else → IDLE.
  - **ECRC:** issues one beat when beat_ready = 1, with no buffer read (rd_en = 0); → IDLE.
- **Reset values:** all outputs 0, pointers 0, buf_count 0, state IDLE. A reset mid-TLP abandons the TLP and discards buffer contents.
- tlp_start outside IDLE is ignored.

## Timing
- rd_en, rd_addr0/1 and rd_loc_num are combinational from state and beat_ready.
- beat_valid, beat_sop, beat_eop, beat_dw_len and ecrc_insert are registered one cycle after the issue. This matches the 1-cycle buffer read latency.
- Descriptor acceptance to first rd_en: 1 cycle.
- Back-to-back TLPs: the next acceptance is in the cycle after returning to IDLE.
- Peak throughput is 8 DW/cycle.

## Configuration
- `DF_ECRC_EN` defined:
  - The ECRC state exists.
  - After the EOP beat, one extra beat follows with beat_valid = 1, ecrc_insert = 1, beat_dw_len = 1, sop = eop = 0.
- `DF_ECRC_EN` undefined:
  - No ECRC state; ecrc_insert is tied to 0.
  - SEND goes directly to IDLE.

## Test plan
- **Reset:** assert rst while in SEND → next cycle all outputs 0, buf_count 0, pointers 0, state IDLE.
- **Single 36-DW TLP:**
  - Stimulus: write 9 locations, then tlp_total_dw = 36 with beat_ready held 1.
  - Expected: 5 beats; rd_loc_num = 2,2,2,2,1; dw_len = 8,8,8,8,4; sop on beat 1, eop on beat 5; buf_count returns to 0.
- **Wrap-around:**
  - Stimulus: wr_ptr = rd_ptr = 255, write 4 locations, read 8 DW.
  - Expected: rd_addr0 = 255, rd_addr1 = 256; next read rd_addr0 = 0, rd_addr1 = 1; wr_ptr = 2.
- **Overflow and simultaneous ops:**
  - Stimulus: buf_count = 250 and wr_loc_num = 9 → wr_ovf pulse, buf_count stays 250.
  - Stimulus: wr_en with 9 and rd_en with 2 in the same cycle from 100.
  - Expected: buf_count = 107.
- **Back-pressure:**
  - Stimulus: deassert beat_ready for 3 cycles mid-TLP.
  - Expected: rd_en = 0 for those cycles; beat_valid drops 1 cycle later; no beat is lost or duplicated.
- **ECRC (both builds), tlp_total_dw = 3:**
  - With DF_ECRC_EN: one beat, dw_len = 3, sop = eop = 1, then an ecrc_insert beat with dw_len = 1.
  - Without DF_ECRC_EN: only the data beat.

Source files
------------

// File: rtl/data_frag_rd_ctrl.sv
// -----------------------------------------------------------------------------
// data_frag_rd_ctrl
// Read-side sequencer and occupancy manager for the TX data-fragmentation TLP
// buffer (257 locations x 4 DW). It keeps the circular write/read pointers and
// the occupancy count. It accepts one TLP descriptor at a time and streams the
// stored TLP out as 8-DW beats, reading two buffer locations per beat.
//
// Optional feature macro: DF_ECRC_EN
//   When defined, an extra ECRC beat follows every EOP beat.
//   When undefined, ecrc_insert is tied low.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   wr_en/wr_loc_num  : buffer write of 1..9 locations this cycle
//   wr_ptr, buf_count : next write address, occupied locations
//   buf_full, wr_ovf  : near-full flag, one-cycle pulse when a write is dropped
//   tlp_start/_total_dw, tlp_ready : descriptor handshake (length in DW)
//   beat_ready        : downstream accepts a beat issued this cycle
//   rd_en, rd_addr0/1, rd_loc_num : combinational buffer read request
//   beat_valid/sop/eop/dw_len, ecrc_insert : beat framing, one cycle after issue
// -----------------------------------------------------------------------------
module data_frag_rd_ctrl #(
    parameter int BUF_DEPTH       = 257,
    parameter int ADDR_WIDTH      = 9,
    parameter int COUNT_WIDTH     = 9,
    parameter int NO_LOC_WR_WIDTH = 4,
    parameter int TLP_DW_WIDTH    = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [NO_LOC_WR_WIDTH-1:0] wr_loc_num,
    output logic [ADDR_WIDTH-1:0]      wr_ptr,
    output logic [COUNT_WIDTH-1:0]     buf_count,
    output logic                       buf_full,
    output logic                       wr_ovf,
    input  logic                       tlp_start,
    input  logic [TLP_DW_WIDTH-1:0]    tlp_total_dw,
    output logic                       tlp_ready,
    input  logic                       beat_ready,
    output logic                       rd_en,
    output logic [ADDR_WIDTH-1:0]      rd_addr0,
    output logic [ADDR_WIDTH-1:0]      rd_addr1,
    output logic [1:0]                 rd_loc_num,
    output logic                       beat_valid,
    output logic                       beat_sop,
    output logic                       beat_eop,
    output logic [3:0]                 beat_dw_len,
    output logic                       ecrc_insert
);

    localparam int CW1 = COUNT_WIDTH + 1;   // count arithmetic with carry room
    localparam int LW  = TLP_DW_WIDTH + 1;  // location arithmetic with carry room
    localparam int BW  = TLP_DW_WIDTH - 2;  // beat counter (max 129 beats)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DF_ECRC_EN
        ECRC = 2'd2,
`endif
        SEND = 2'd1
    } state_t;

    state_t                     state_q;
    logic [ADDR_WIDTH-1:0]      wr_ptr_q, rd_ptr_q;
    logic [COUNT_WIDTH-1:0]     count_q, count_d;
    logic                       ovf_q;
    logic [BW-1:0]              beats_left_q;
    logic                       loc_odd_q;
    logic [3:0]                 last_len_q;
    logic                       first_q;
    logic                       bv_q, sop_q, eop_q;
    logic [3:0]                 len_q;

    logic [CW1-1:0]             wr_sum_s, cnt_full_s;
    logic                       wr_drop_s, wr_acc_s;
    logic                       last_beat_s, rd_en_s;
    logic [1:0]                 rd_loc_s;
    logic [LW-1:0]              need_loc_s;
    logic [BW-1:0]              need_beat_s;
    logic [2:0]                 dw_m1_s;
    logic                       tlp_ready_s;

    // Circular pointer advance modulo BUF_DEPTH (n is at most 9, so one wrap suffices).
    function automatic logic [ADDR_WIDTH-1:0] ptr_add(input logic [ADDR_WIDTH-1:0] ptr,
                                                      input logic [NO_LOC_WR_WIDTH-1:0] n);
        logic [ADDR_WIDTH:0] s;
        s = {1'b0, ptr} + {{(ADDR_WIDTH + 1 - NO_LOC_WR_WIDTH){1'b0}}, n};
        if (s >= (ADDR_WIDTH + 1)'(BUF_DEPTH)) begin
            s = s - (ADDR_WIDTH + 1)'(BUF_DEPTH);
        end
        return s[ADDR_WIDTH-1:0];
    endfunction

    // Write admission, read request, descriptor sizing and next occupancy.
    always_comb begin
        wr_sum_s    = {1'b0, count_q} + CW1'(wr_loc_num);
        wr_drop_s   = wr_en && (wr_sum_s > CW1'(BUF_DEPTH));
        wr_acc_s    = wr_en && !wr_drop_s;
        last_beat_s = (beats_left_q == BW'(1));
        rd_en_s     = (state_q == SEND) && beat_ready;
        // Odd location count: the final beat carries only one location.
        if (last_beat_s && loc_odd_q) begin
            rd_loc_s = 2'd1;
        end else begin
            rd_loc_s = 2'd2;
        end
        need_loc_s  = ({1'b0, tlp_total_dw} + LW'(3)) >> 2;
        need_beat_s = BW'(({1'b0, tlp_total_dw} + LW'(7)) >> 3);
        // Last-beat length is ((dw-1) mod 8) + 1, i.e. dw - 8*(B-1).
        dw_m1_s     = 3'(tlp_total_dw - TLP_DW_WIDTH'(1));
        tlp_ready_s = (state_q == IDLE) && (LW'(count_q) >= need_loc_s);
        cnt_full_s  = {1'b0, count_q};
        if (wr_acc_s) begin
            cnt_full_s = cnt_full_s + CW1'(wr_loc_num);
        end else begin
            cnt_full_s = cnt_full_s;
        end
        if (rd_en_s) begin
            cnt_full_s = cnt_full_s - CW1'(rd_loc_s);
        end else begin
            cnt_full_s = cnt_full_s;
        end
        count_d = cnt_full_s[COUNT_WIDTH-1:0];
    end

    // Pointer, occupancy and overflow-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_q <= ptr_add(wr_ptr_q, wr_loc_num);
            end
            if (rd_en_s) begin
                rd_ptr_q <= ptr_add(rd_ptr_q, NO_LOC_WR_WIDTH'(rd_loc_s));
            end
            count_q <= count_d;
            ovf_q   <= wr_drop_s;
        end
    end

`ifdef DF_ECRC_EN
    logic ecrc_q;
`endif

    // Sequencer FSM with registered beat framing (aligned to buffer read latency).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            loc_odd_q    <= 1'b0;
            last_len_q   <= 4'd0;
            first_q      <= 1'b0;
            bv_q         <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            len_q        <= 4'd0;
`ifdef DF_ECRC_EN
            ecrc_q       <= 1'b0;
`endif
        end else begin
            bv_q  <= 1'b0;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
            len_q <= 4'd0;
`ifdef DF_ECRC_EN
            ecrc_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (tlp_start && tlp_ready_s) begin
                        beats_left_q <= need_beat_s;
                        loc_odd_q    <= need_loc_s[0];
                        last_len_q   <= {1'b0, dw_m1_s} + 4'd1;
                        first_q      <= 1'b1;
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    if (beat_ready) begin
                        bv_q         <= 1'b1;
                        sop_q        <= first_q;
                        eop_q        <= last_beat_s;
                        len_q        <= last_beat_s ? last_len_q : 4'd8;
                        first_q      <= 1'b0;
                        beats_left_q <= beats_left_q - BW'(1);
                        if (last_beat_s) begin
`ifdef DF_ECRC_EN
                            state_q <= ECRC;
`else
                            state_q <= IDLE;
`endif
                        end
                    end
                end
`ifdef DF_ECRC_EN
                ECRC: begin
                    if (beat_ready) begin
                        bv_q    <= 1'b1;
                        ecrc_q  <= 1'b1;
                        len_q   <= 4'd1;
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_ptr      = wr_ptr_q;
    assign buf_count   = count_q;
    assign buf_full    = (count_q > COUNT_WIDTH'(BUF_DEPTH - 9));
    assign wr_ovf      = ovf_q;
    assign tlp_ready   = tlp_ready_s;
    assign rd_en       = rd_en_s;
    // Read address/size are driven only during a read so idle outputs stay 0.
    assign rd_addr0    = rd_en_s ? rd_ptr_q : '0;
    assign rd_addr1    = rd_en_s ? ptr_add(rd_ptr_q, NO_LOC_WR_WIDTH'(1)) : '0;
    assign rd_loc_num  = rd_en_s ? rd_loc_s : 2'd0;
    assign beat_valid  = bv_q;
    assign beat_sop    = sop_q;
    assign beat_eop    = eop_q;
    assign beat_dw_len = len_q;
`ifdef DF_ECRC_EN
    assign ecrc_insert = ecrc_q;
`else
    assign ecrc_insert = 1'b0;
`endif

endmodule
